// File: rtl/mvm_param_pkg.sv
// Shared state encoding, default geometry and width helper for mvm_param.
package mvm_param_pkg;

   typedef enum logic [1:0] {LOAD_A, LOAD_X, COMPUTE, DRAIN} state_e;

   // Counter width that stays legal (>= 1 bit) for degenerate sizes.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_M      = 4;
   localparam int DEF_N      = 4;
   localparam int DEF_P      = 2;
   localparam int MAT_SIZE   = DEF_M * DEF_N;
   localparam int BANK_DEPTH = (DEF_M / DEF_P) * DEF_N;
   localparam int MAT_AW     = cnt_w(MAT_SIZE);
   localparam int BANK_AW    = cnt_w(BANK_DEPTH);

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: registered signed accumulate with sticky overflow.
// Define MVM_PARAM_SAT_EN to saturate the result of an overflowed row.
module mvm_mac_lane #(
   parameter int WIDTH_IN  = 8,
   parameter int WIDTH_OUT = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        valid_in,
   input  logic                        clear,
   input  logic signed [WIDTH_IN-1:0]  a,
   input  logic signed [WIDTH_IN-1:0]  x,
   output logic signed [WIDTH_OUT-1:0] result,
   output logic                        overflow
);

   logic signed [2*WIDTH_IN-1:0] prod;
   logic signed [WIDTH_OUT-1:0]  prod_ext;
   logic signed [WIDTH_OUT-1:0]  acc_base;
   logic signed [WIDTH_OUT-1:0]  sum;
   logic signed [WIDTH_OUT-1:0]  acc_q;
   logic                         add_ovf;
   logic                         ovf_q;

   assign prod     = (2*WIDTH_IN)'(a) * (2*WIDTH_IN)'(x);
   assign prod_ext = WIDTH_OUT'(prod);
   assign acc_base = clear ? '0 : acc_q;
   assign sum      = acc_base + prod_ext;
   // Same-sign operands whose wrapped sum flips sign left the signed range.
   assign add_ovf  = (acc_base[WIDTH_OUT-1] == prod_ext[WIDTH_OUT-1]) &&
                     (sum[WIDTH_OUT-1] != acc_base[WIDTH_OUT-1]);

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else if (valid_in) begin
         acc_q <= sum;
         ovf_q <= (ovf_q & ~clear) | add_ovf;
      end
   end

   assign overflow = ovf_q;

`ifdef MVM_PARAM_SAT_EN
   logic ovf_pos_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_pos_q <= 1'b0;
      end else if (valid_in && add_ovf) begin
         ovf_pos_q <= ~acc_base[WIDTH_OUT-1];
      end
   end

   always_comb begin
      result = acc_q;
      if (ovf_q) begin
         result = ovf_pos_q ? {1'b0, {(WIDTH_OUT-1){1'b1}}} : {1'b1, {(WIDTH_OUT-1){1'b0}}};
      end
   end
`else
   assign result = acc_q;
`endif

endmodule

// File: rtl/mvm_param.sv
// Parametrised y = A*x with P MAC lanes, streamed valid/ready in and out.
// Define MVM_PARAM_SAT_EN to saturate overflowed results instead of wrapping.
module mvm_param
   import mvm_param_pkg::*;
#(
   parameter int M         = DEF_M,
   parameter int N         = DEF_N,
   parameter int P         = DEF_P,
   parameter int WIDTH_IN  = 8,
   parameter int WIDTH_OUT = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic signed [WIDTH_IN-1:0]  data_in,
   input  logic                        reuse_a,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic signed [WIDTH_OUT-1:0] data_out,
   output logic                        overflow
);

   localparam int DEPTH = (M / P) * N;
   localparam int AW    = cnt_w(DEPTH);
   localparam int CW    = cnt_w(N);
   localparam int LW    = cnt_w(P);
   localparam int PW    = cnt_w(M / P);
   localparam int KW    = cnt_w(N + 2);

   state_e state_q, state_d;

   logic [CW-1:0] col_q;
   logic [LW-1:0] lane_q;
   logic [AW-1:0] base_q;
   logic [PW-1:0] pass_q;
   logic [AW-1:0] pass_base_q;
   logic [KW-1:0] k_q;
   logic [LW-1:0] drain_q;

   logic s_hs, m_hs, a_we, x_we, issue;
   logic last_col, last_lane, last_base, last_pass, k_done, drain_last;
   logic [AW-1:0] rd_addr;
   logic rd_valid_q, rd_clear_q;

   logic signed [WIDTH_IN-1:0]  a_mem [P][DEPTH];
   logic signed [WIDTH_IN-1:0]  x_mem [N];
   logic signed [WIDTH_IN-1:0]  a_rd  [P];
   logic signed [WIDTH_IN-1:0]  x_rd;
   logic signed [WIDTH_OUT-1:0] lane_res   [P];
   logic [P-1:0]                lane_ovf;
   logic signed [WIDTH_OUT-1:0] out_data_q [P];
   logic [P-1:0]                out_ovf_q;

   assign s_ready    = (state_q == LOAD_A) || (state_q == LOAD_X);
   assign m_valid    = (state_q == DRAIN);
   assign s_hs       = s_valid && s_ready;
   assign m_hs       = m_valid && m_ready;
   assign a_we       = s_hs && (state_q == LOAD_A);
   assign x_we       = s_hs && (state_q == LOAD_X);
   assign issue      = (state_q == COMPUTE) && (k_q < KW'(N));
   assign last_col   = (col_q == CW'(N - 1));
   assign last_lane  = (lane_q == LW'(P - 1));
   assign last_base  = (base_q == AW'(DEPTH - N));
   assign last_pass  = (pass_q == PW'(M / P - 1));
   assign k_done     = (k_q == KW'(N + 1));
   assign drain_last = (drain_q == LW'(P - 1));
   assign rd_addr    = pass_base_q + AW'(k_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= LOAD_A;
      else        state_q <= state_d;
   end

   // NOTE: state_d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD_A:  if (a_we && last_col && last_lane && last_base) state_d = LOAD_X;
         LOAD_X:  if (x_we && last_col) state_d = COMPUTE;
         COMPUTE: if (k_done) state_d = DRAIN;
         DRAIN: begin
            if (m_hs && drain_last) begin
               if (!last_pass)   state_d = COMPUTE;
               else if (reuse_a) state_d = LOAD_X;
               else              state_d = LOAD_A;
            end
         end
         default: state_d = LOAD_A;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q       <= '0;
         lane_q      <= '0;
         base_q      <= '0;
         pass_q      <= '0;
         pass_base_q <= '0;
         k_q         <= '0;
         drain_q     <= '0;
      end else begin
         case (state_q)
            LOAD_A: begin
               if (a_we) begin
                  if (last_col) begin
                     col_q <= '0;
                     if (last_lane) begin
                        lane_q <= '0;
                        base_q <= last_base ? '0 : base_q + AW'(N);
                     end else begin
                        lane_q <= lane_q + LW'(1);
                     end
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end
            end
            LOAD_X: if (x_we) col_q <= last_col ? '0 : col_q + CW'(1);
            COMPUTE: k_q <= k_done ? '0 : k_q + KW'(1);
            DRAIN: begin
               if (m_hs) begin
                  if (drain_last) begin
                     drain_q     <= '0;
                     pass_q      <= last_pass ? '0 : pass_q + PW'(1);
                     pass_base_q <= last_pass ? '0 : pass_base_q + AW'(N);
                  end else begin
                     drain_q <= drain_q + LW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: storage arrays carry no reset; their contents are always written before being read.
   always_ff @(posedge clk) begin
      if (a_we) a_mem[lane_q][base_q + AW'(col_q)] <= data_in;
      if (x_we) x_mem[col_q] <= data_in;
      if (issue) begin
         for (int p = 0; p < P; p++) a_rd[p] <= a_mem[p][rd_addr];
         x_rd <= x_mem[CW'(k_q)];
      end
   end

   // Lane control follows the read data by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_clear_q <= 1'b0;
      end else begin
         rd_valid_q <= issue;
         rd_clear_q <= (k_q == '0);
      end
   end

   for (genvar p = 0; p < P; p++) begin : g_lane
      mvm_mac_lane #(
         .WIDTH_IN  (WIDTH_IN),
         .WIDTH_OUT (WIDTH_OUT)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .valid_in (rd_valid_q),
         .clear    (rd_clear_q),
         .a        (a_rd[p]),
         .x        (x_rd),
         .result   (lane_res[p]),
         .overflow (lane_ovf[p])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < P; p++) out_data_q[p] <= '0;
         out_ovf_q <= '0;
      end else if ((state_q == COMPUTE) && k_done) begin
         for (int p = 0; p < P; p++) out_data_q[p] <= lane_res[p];
         out_ovf_q <= lane_ovf;
      end
   end

   assign data_out = out_data_q[drain_q];
   assign overflow = out_ovf_q[drain_q];

endmodule
